// File: rtl/control_unit_pkg.sv
// Shared MIPS32 ISA table for the control decoder: encodings, ALU/data-type codes,
// control-word bit positions and the common control-bit groupings.
package control_unit_pkg;

   localparam int CW_W = 22;

   localparam int B_HI_WRITE   = 21;
   localparam int B_HI_READ    = 20;
   localparam int B_LO_WRITE   = 19;
   localparam int B_LO_READ    = 18;
   localparam int B_IFUNSIGNED = 17;
   localparam int B_REGDST     = 16;
   localparam int B_ALUSRC     = 15;
   localparam int B_MEMTOREG   = 14;
   localparam int B_REGWRITE   = 13;
   localparam int B_MEMREAD    = 12;
   localparam int B_MEMWRITE   = 11;
   localparam int B_BRANCH     = 10;
   localparam int B_JUMP       = 9;
   localparam int B_LINKED     = 8;
   localparam int B_RETURN     = 7;
   localparam int B_ALUOP_LSB  = 3;
   localparam int B_SHIFT_V    = 2;
   localparam int B_DT_LSB     = 0;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU,
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI, ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU
   } aluop_e;

   typedef enum logic [1:0] {DT_WORD, DT_HALF, DT_BYTE, DT_PART} dtype_e;

   localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02,
                          OP_JAL     = 6'h03, OP_BEQ    = 6'h04, OP_BNE   = 6'h05,
                          OP_BLEZ    = 6'h06, OP_BGTZ   = 6'h07, OP_ADDI  = 6'h08,
                          OP_ADDIU   = 6'h09, OP_SLTI   = 6'h0A, OP_SLTIU = 6'h0B,
                          OP_ANDI    = 6'h0C, OP_ORI    = 6'h0D, OP_XORI  = 6'h0E,
                          OP_LUI     = 6'h0F, OP_LB     = 6'h20, OP_LH    = 6'h21,
                          OP_LWL     = 6'h22, OP_LW     = 6'h23, OP_LBU   = 6'h24,
                          OP_LHU     = 6'h25, OP_LWR    = 6'h26, OP_SB    = 6'h28,
                          OP_SH      = 6'h29, OP_SWL    = 6'h2A, OP_SW    = 6'h2B,
                          OP_SWR     = 6'h2E;

   localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA   = 6'h03,
                          FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_SRAV  = 6'h07,
                          FN_JR   = 6'h08, FN_JALR = 6'h09, FN_MFHI  = 6'h10,
                          FN_MTHI = 6'h11, FN_MFLO = 6'h12, FN_MTLO  = 6'h13,
                          FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV  = 6'h1A,
                          FN_DIVU = 6'h1B, FN_ADD  = 6'h20, FN_ADDU  = 6'h21,
                          FN_SUB  = 6'h22, FN_SUBU = 6'h23, FN_AND   = 6'h24,
                          FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_NOR   = 6'h27,
                          FN_SLT  = 6'h2A, FN_SLTU = 6'h2B;

   localparam logic [4:0] RT_BLTZ = 5'h00;

   localparam logic [CW_W-1:0] M_HI_WRITE   = CW_W'(1) << B_HI_WRITE;
   localparam logic [CW_W-1:0] M_HI_READ    = CW_W'(1) << B_HI_READ;
   localparam logic [CW_W-1:0] M_LO_WRITE   = CW_W'(1) << B_LO_WRITE;
   localparam logic [CW_W-1:0] M_LO_READ    = CW_W'(1) << B_LO_READ;
   localparam logic [CW_W-1:0] M_IFUNSIGNED = CW_W'(1) << B_IFUNSIGNED;
   localparam logic [CW_W-1:0] M_REGDST     = CW_W'(1) << B_REGDST;
   localparam logic [CW_W-1:0] M_ALUSRC     = CW_W'(1) << B_ALUSRC;
   localparam logic [CW_W-1:0] M_MEMTOREG   = CW_W'(1) << B_MEMTOREG;
   localparam logic [CW_W-1:0] M_REGWRITE   = CW_W'(1) << B_REGWRITE;
   localparam logic [CW_W-1:0] M_MEMREAD    = CW_W'(1) << B_MEMREAD;
   localparam logic [CW_W-1:0] M_MEMWRITE   = CW_W'(1) << B_MEMWRITE;
   localparam logic [CW_W-1:0] M_BRANCH     = CW_W'(1) << B_BRANCH;
   localparam logic [CW_W-1:0] M_JUMP       = CW_W'(1) << B_JUMP;
   localparam logic [CW_W-1:0] M_LINKED     = CW_W'(1) << B_LINKED;
   localparam logic [CW_W-1:0] M_RETURN     = CW_W'(1) << B_RETURN;
   localparam logic [CW_W-1:0] M_SHIFT_V    = CW_W'(1) << B_SHIFT_V;

   // Recurring instruction-class groupings
   localparam logic [CW_W-1:0] M_RTYPE = M_REGDST | M_REGWRITE;
   localparam logic [CW_W-1:0] M_ITYPE = M_ALUSRC | M_REGWRITE;
   localparam logic [CW_W-1:0] M_LOAD  = M_ALUSRC | M_MEMTOREG | M_REGWRITE | M_MEMREAD;
   localparam logic [CW_W-1:0] M_STORE = M_ALUSRC | M_MEMWRITE;

   function automatic logic [CW_W-1:0] alu_f(aluop_e op);
      return CW_W'(op) << B_ALUOP_LSB;
   endfunction

   function automatic logic [CW_W-1:0] dt_f(dtype_e dt);
      return CW_W'(dt) << B_DT_LSB;
   endfunction

endpackage

// File: rtl/control_unit.sv
// MIPS32 main decoder: combinational control word plus a sticky registered
// flag recording that an unsupported encoding was ever presented.
module control_unit
   import control_unit_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic [5:0]      opcode,
   input  logic [5:0]      funct,
   input  logic [4:0]      rt,
   output logic [CW_W-1:0] control_word,
   output logic            illegal,
   output logic            illegal_seen
);

   always_comb begin
      control_word = '0;
      illegal      = 1'b0;
      case (opcode)
         OP_J:      control_word = M_JUMP;
         OP_JAL:    control_word = M_JUMP | M_LINKED | M_REGWRITE;
         OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:
                    control_word = M_BRANCH | alu_f(ALU_SUB);
         OP_REGIMM: begin
            if (rt == RT_BLTZ) control_word = M_BRANCH | alu_f(ALU_SUB);
            else               illegal      = 1'b1;
         end
         OP_ADDI:   control_word = M_ITYPE | alu_f(ALU_ADD);
         OP_ADDIU:  control_word = M_ITYPE | M_IFUNSIGNED | alu_f(ALU_ADD);
         OP_SLTI:   control_word = M_ITYPE | alu_f(ALU_SLT);
         OP_SLTIU:  control_word = M_ITYPE | M_IFUNSIGNED | alu_f(ALU_SLTU);
         OP_ANDI:   control_word = M_ITYPE | M_IFUNSIGNED | alu_f(ALU_AND);
         OP_ORI:    control_word = M_ITYPE | M_IFUNSIGNED | alu_f(ALU_OR);
         OP_XORI:   control_word = M_ITYPE | M_IFUNSIGNED | alu_f(ALU_XOR);
         OP_LUI:    control_word = M_ITYPE | alu_f(ALU_LUI);
         OP_LB:     control_word = M_LOAD | dt_f(DT_BYTE);
         OP_LH:     control_word = M_LOAD | dt_f(DT_HALF);
         OP_LW:     control_word = M_LOAD | dt_f(DT_WORD);
         OP_LWL, OP_LWR:
                    control_word = M_LOAD | dt_f(DT_PART);
         OP_LBU:    control_word = M_LOAD | M_IFUNSIGNED | dt_f(DT_BYTE);
         OP_LHU:    control_word = M_LOAD | M_IFUNSIGNED | dt_f(DT_HALF);
         OP_SB:     control_word = M_STORE | dt_f(DT_BYTE);
         OP_SH:     control_word = M_STORE | dt_f(DT_HALF);
         OP_SW:     control_word = M_STORE | dt_f(DT_WORD);
         OP_SWL, OP_SWR:
                    control_word = M_STORE | dt_f(DT_PART);
         OP_SPECIAL: begin
            case (funct)
               FN_SLL:   control_word = M_RTYPE | alu_f(ALU_SLL);
               FN_SRL:   control_word = M_RTYPE | alu_f(ALU_SRL);
               FN_SRA:   control_word = M_RTYPE | alu_f(ALU_SRA);
               FN_SLLV:  control_word = M_RTYPE | M_SHIFT_V | alu_f(ALU_SLL);
               FN_SRLV:  control_word = M_RTYPE | M_SHIFT_V | alu_f(ALU_SRL);
               FN_SRAV:  control_word = M_RTYPE | M_SHIFT_V | alu_f(ALU_SRA);
               FN_JR:    control_word = M_JUMP | M_RETURN;
               FN_JALR:  control_word = M_JUMP | M_RETURN | M_LINKED | M_RTYPE;
               FN_MFHI:  control_word = M_HI_READ | M_RTYPE;
               FN_MFLO:  control_word = M_LO_READ | M_RTYPE;
               FN_MTHI:  control_word = M_HI_WRITE;
               FN_MTLO:  control_word = M_LO_WRITE;
               FN_MULT:  control_word = M_HI_WRITE | M_LO_WRITE | alu_f(ALU_MULT);
               FN_MULTU: control_word = M_HI_WRITE | M_LO_WRITE | M_IFUNSIGNED | alu_f(ALU_MULTU);
               FN_DIV:   control_word = M_HI_WRITE | M_LO_WRITE | alu_f(ALU_DIV);
               FN_DIVU:  control_word = M_HI_WRITE | M_LO_WRITE | M_IFUNSIGNED | alu_f(ALU_DIVU);
               FN_ADD:   control_word = M_RTYPE | alu_f(ALU_ADD);
               FN_ADDU:  control_word = M_RTYPE | M_IFUNSIGNED | alu_f(ALU_ADD);
               FN_SUB:   control_word = M_RTYPE | alu_f(ALU_SUB);
               FN_SUBU:  control_word = M_RTYPE | M_IFUNSIGNED | alu_f(ALU_SUB);
               FN_AND:   control_word = M_RTYPE | alu_f(ALU_AND);
               FN_OR:    control_word = M_RTYPE | alu_f(ALU_OR);
               FN_XOR:   control_word = M_RTYPE | alu_f(ALU_XOR);
               FN_NOR:   control_word = M_RTYPE | alu_f(ALU_NOR);
               FN_SLT:   control_word = M_RTYPE | alu_f(ALU_SLT);
               FN_SLTU:  control_word = M_RTYPE | M_IFUNSIGNED | alu_f(ALU_SLTU);
               default:  illegal = 1'b1;
            endcase
         end
         default:   illegal = 1'b1;
      endcase
   end

   // Reset wins over an illegal encoding present at the same edge
   always_ff @(posedge clk) begin
      if (rst)          illegal_seen <= 1'b0;
      else if (illegal) illegal_seen <= 1'b1;
   end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: golden-table sweep of every supported
// encoding, illegal encodings, and the sticky flag's reset/priority behaviour.
module tb_control_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  opcode, funct;
   logic [4:0]  rt;
   logic [21:0] control_word;
   logic        illegal, illegal_seen;

   control_unit dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .rt(rt),
      .control_word(control_word), .illegal(illegal), .illegal_seen(illegal_seen)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [21:0] cw;
      logic        ill;
   } exp_t;

   typedef struct {
      string    name;
      bit [5:0] op;
      bit [5:0] fn;
      bit [4:0] rt;
      bit [21:0] cw;
   } row_t;

   exp_t sb[$];
   row_t golden[$];
   int   checks   = 0;
   int   failures = 0;
   logic exp_seen = 1'b0;
   logic cur_ill  = 1'b0;

   task automatic add_row(input string n, input bit [5:0] op, input bit [5:0] fn,
                          input bit [4:0] r, input bit [21:0] cw);
      row_t x;
      x.name = n; x.op = op; x.fn = fn; x.rt = r; x.cw = cw;
      golden.push_back(x);
   endtask

   // Fields the decoder must ignore are driven with random values.
   task automatic apply(input string tag, input bit [5:0] op, input bit [5:0] fn,
                        input bit [4:0] r, input logic [21:0] ecw, input logic eill);
      exp_t e;
      opcode = op;
      funct  = (op == 6'h00) ? fn : 6'($urandom);
      rt     = (op == 6'h01) ? r  : 5'($urandom);
      sb.push_back('{tag, ecw, eill});
      cur_ill = eill;
      #1;
      e = sb.pop_front();
      checks++;
      assert (control_word === e.cw) else begin
         failures++;
         $error("FAIL %s control_word observed=%h expected=%h", e.tag, control_word, e.cw);
      end
      checks++;
      assert (illegal === e.ill) else begin
         failures++;
         $error("FAIL %s illegal observed=%b expected=%b", e.tag, illegal, e.ill);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      exp_seen = rst ? 1'b0 : (exp_seen | cur_ill);
      #1;
   endtask

   task automatic check_seen(input string tag);
      checks++;
      assert (illegal_seen === exp_seen) else begin
         failures++;
         $error("FAIL %s illegal_seen observed=%b expected=%b", tag, illegal_seen, exp_seen);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      add_row("J",     6'h02, 6'h00, 5'h00, 22'h000200);
      add_row("JAL",   6'h03, 6'h00, 5'h00, 22'h002300);
      add_row("BEQ",   6'h04, 6'h00, 5'h00, 22'h000408);
      add_row("BNE",   6'h05, 6'h00, 5'h00, 22'h000408);
      add_row("BLEZ",  6'h06, 6'h00, 5'h00, 22'h000408);
      add_row("BGTZ",  6'h07, 6'h00, 5'h00, 22'h000408);
      add_row("BLTZ",  6'h01, 6'h00, 5'h00, 22'h000408);
      add_row("ADDI",  6'h08, 6'h00, 5'h00, 22'h00A000);
      add_row("ADDIU", 6'h09, 6'h00, 5'h00, 22'h02A000);
      add_row("SLTI",  6'h0A, 6'h00, 5'h00, 22'h00A030);
      add_row("SLTIU", 6'h0B, 6'h00, 5'h00, 22'h02A038);
      add_row("ANDI",  6'h0C, 6'h00, 5'h00, 22'h02A010);
      add_row("ORI",   6'h0D, 6'h00, 5'h00, 22'h02A018);
      add_row("XORI",  6'h0E, 6'h00, 5'h00, 22'h02A020);
      add_row("LUI",   6'h0F, 6'h00, 5'h00, 22'h00A058);
      add_row("LB",    6'h20, 6'h00, 5'h00, 22'h00F002);
      add_row("LH",    6'h21, 6'h00, 5'h00, 22'h00F001);
      add_row("LWL",   6'h22, 6'h00, 5'h00, 22'h00F003);
      add_row("LW",    6'h23, 6'h00, 5'h00, 22'h00F000);
      add_row("LBU",   6'h24, 6'h00, 5'h00, 22'h02F002);
      add_row("LHU",   6'h25, 6'h00, 5'h00, 22'h02F001);
      add_row("LWR",   6'h26, 6'h00, 5'h00, 22'h00F003);
      add_row("SB",    6'h28, 6'h00, 5'h00, 22'h008802);
      add_row("SH",    6'h29, 6'h00, 5'h00, 22'h008801);
      add_row("SWL",   6'h2A, 6'h00, 5'h00, 22'h008803);
      add_row("SW",    6'h2B, 6'h00, 5'h00, 22'h008800);
      add_row("SWR",   6'h2E, 6'h00, 5'h00, 22'h008803);
      add_row("SLL",   6'h00, 6'h00, 5'h00, 22'h012040);
      add_row("SRL",   6'h00, 6'h02, 5'h00, 22'h012048);
      add_row("SRA",   6'h00, 6'h03, 5'h00, 22'h012050);
      add_row("SLLV",  6'h00, 6'h04, 5'h00, 22'h012044);
      add_row("SRLV",  6'h00, 6'h06, 5'h00, 22'h01204C);
      add_row("SRAV",  6'h00, 6'h07, 5'h00, 22'h012054);
      add_row("JR",    6'h00, 6'h08, 5'h00, 22'h000280);
      add_row("JALR",  6'h00, 6'h09, 5'h00, 22'h012380);
      add_row("MFHI",  6'h00, 6'h10, 5'h00, 22'h112000);
      add_row("MTHI",  6'h00, 6'h11, 5'h00, 22'h200000);
      add_row("MFLO",  6'h00, 6'h12, 5'h00, 22'h052000);
      add_row("MTLO",  6'h00, 6'h13, 5'h00, 22'h080000);
      add_row("MULT",  6'h00, 6'h18, 5'h00, 22'h280060);
      add_row("MULTU", 6'h00, 6'h19, 5'h00, 22'h2A0068);
      add_row("DIV",   6'h00, 6'h1A, 5'h00, 22'h280070);
      add_row("DIVU",  6'h00, 6'h1B, 5'h00, 22'h2A0078);
      add_row("ADD",   6'h00, 6'h20, 5'h00, 22'h012000);
      add_row("ADDU",  6'h00, 6'h21, 5'h00, 22'h032000);
      add_row("SUB",   6'h00, 6'h22, 5'h00, 22'h012008);
      add_row("SUBU",  6'h00, 6'h23, 5'h00, 22'h032008);
      add_row("AND",   6'h00, 6'h24, 5'h00, 22'h012010);
      add_row("OR",    6'h00, 6'h25, 5'h00, 22'h012018);
      add_row("XOR",   6'h00, 6'h26, 5'h00, 22'h012020);
      add_row("NOR",   6'h00, 6'h27, 5'h00, 22'h012028);
      add_row("SLT",   6'h00, 6'h2A, 5'h00, 22'h012030);
      add_row("SLTU",  6'h00, 6'h2B, 5'h00, 22'h032038);

      // Reset state; decode must be live while rst is high
      rst = 1'b1;
      apply("ADD_in_rst", 6'h00, 6'h20, 5'h00, 22'h012000, 1'b0);
      tick();
      tick();
      check_seen("reset_state");

      rst = 1'b0;
      foreach (golden[i])
         apply(golden[i].name, golden[i].op, golden[i].fn, golden[i].rt, golden[i].cw, 1'b0);
      tick();
      check_seen("legal_sweep_no_seen");

      // Illegal REGIMM rt: flag only after the edge
      apply("REGIMM_rt1", 6'h01, 6'h00, 5'h01, 22'h0, 1'b1);
      check_seen("seen_before_edge");
      tick();
      check_seen("seen_after_regimm");

      apply("LW_after_illegal", 6'h23, 6'h00, 5'h00, 22'h00F000, 1'b0);
      tick();
      check_seen("seen_sticky");

      // Reset has priority over a simultaneous illegal encoding
      rst = 1'b1;
      apply("SPECIAL_3F_in_rst", 6'h00, 6'h3F, 5'h00, 22'h0, 1'b1);
      tick();
      check_seen("rst_priority");
      apply("SPECIAL_3F_post_rst", 6'h00, 6'h3F, 5'h00, 22'h0, 1'b1);

      rst = 1'b0;
      tick();
      check_seen("seen_after_fn3F");
      rst = 1'b1;
      apply("SW_in_rst", 6'h2B, 6'h00, 5'h00, 22'h008800, 1'b0);
      tick();
      check_seen("rst_clears");
      rst = 1'b0;

      apply("SPECIAL_fn01", 6'h00, 6'h01, 5'h00, 22'h0, 1'b1);
      apply("SPECIAL_fn05", 6'h00, 6'h05, 5'h00, 22'h0, 1'b1);
      apply("SPECIAL_fn0C", 6'h00, 6'h0C, 5'h00, 22'h0, 1'b1);
      apply("REGIMM_rt11",  6'h01, 6'h00, 5'h11, 22'h0, 1'b1);
      apply("OP_10",        6'h10, 6'h20, 5'h00, 22'h0, 1'b1);
      apply("OP_27",        6'h27, 6'h00, 5'h00, 22'h0, 1'b1);
      apply("OP_2F",        6'h2F, 6'h00, 5'h00, 22'h0, 1'b1);
      apply("OP_3F",        6'h3F, 6'h00, 5'h00, 22'h0, 1'b1);
      tick();
      check_seen("seen_after_misc_illegal");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
